// File: rtl/video_timing_pkg.sv
// Shared timing defaults, derived totals and FSM state
// encoding for the video timing generator.
package video_timing_pkg;

   localparam int H_ACT_DEF  = 1280;
   localparam int H_FP_DEF   = 110;
   localparam int H_SYNC_DEF = 40;
   localparam int H_BP_DEF   = 220;
   localparam int V_ACT_DEF  = 720;
   localparam int V_FP_DEF   = 5;
   localparam int V_SYNC_DEF = 5;
   localparam int V_BP_DEF   = 20;

   localparam int H_TOT_DEF =
      H_ACT_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOT_DEF =
      V_ACT_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   // Counter width able to hold 0..m-1 (at least 1 bit).
   function automatic int cw(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/video_timing_gen_wrap_counter.sv
// Modulo-MOD up counter with enable, clear and terminal count.
// Ports: clk, rst (sync, high), en, clr, cnt, tc (cnt==MOD-1).
module wrap_counter
   import video_timing_pkg::*;
#(
   parameter int MOD = 2,
   parameter int W   = cw(MOD)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         tc
);

   assign tc = (cnt == W'(MOD - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, sync, blanking,
// active coordinates, frame pulses and a frame counter.
// Ports: clk, rst (sync, high), run (level) -> hsync, vsync,
// blank, col, row, sof, eof, frame_cnt, busy (all registered).
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACT  = H_ACT_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_ACT  = V_ACT_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic        hsync,
   output logic        vsync,
   output logic        blank,
   output logic [10:0] col,
   output logic [9:0]  row,
   output logic        sof,
   output logic        eof,
   output logic [7:0]  frame_cnt,
   output logic        busy
);

   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int HW    = cw(H_TOT);
   localparam int VW    = cw(V_TOT);

   localparam logic [HW-1:0] H_A  = HW'(H_ACT);
   localparam logic [HW-1:0] H_AL = HW'(H_ACT - 1);
   localparam logic [HW-1:0] H_S0 = HW'(H_ACT + H_FP);
   localparam logic [HW-1:0] H_S1 =
      HW'(H_ACT + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_A  = VW'(V_ACT);
   localparam logic [VW-1:0] V_AL = VW'(V_ACT - 1);
   localparam logic [VW-1:0] V_S0 = VW'(V_ACT + V_FP);
   localparam logic [VW-1:0] V_S1 =
      VW'(V_ACT + V_FP + V_SYNC - 1);

   state_t        state;
   state_t        state_nxt;
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          h_tc;
   logic          v_tc;
   logic          cnt_en;
   logic          cnt_clr;
   logic          last;
   logic          act;

   assign last = h_tc & v_tc;
   assign act  = (h < H_A) && (v < V_A);

   wrap_counter #(.MOD(H_TOT), .W(HW)) u_h (
      .clk (clk),
      .rst (rst),
      .en  (cnt_en),
      .clr (cnt_clr),
      .cnt (h),
      .tc  (h_tc)
   );

   wrap_counter #(.MOD(V_TOT), .W(VW)) u_v (
      .clk (clk),
      .rst (rst),
      .en  (cnt_en & h_tc),
      .clr (cnt_clr),
      .cnt (v),
      .tc  (v_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (run) state_nxt = RUN;
         end
         RUN: begin
            cnt_en = 1'b1;
            // Dropping run on the very last position ends the
            // frame now instead of draining a whole new frame.
            if (!run) state_nxt = last ? IDLE : DRAIN;
         end
         DRAIN: begin
            cnt_en = 1'b1;
            if (run) begin
               state_nxt = RUN;
            end else if (last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs describe the counter position of the previous cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync     <= 1'b0;
         vsync     <= 1'b0;
         blank     <= 1'b1;
         col       <= '0;
         row       <= '0;
         sof       <= 1'b0;
         eof       <= 1'b0;
         busy      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         busy <= (state != IDLE);
         if (state == IDLE) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
            blank <= 1'b1;
            col   <= '0;
            row   <= '0;
            sof   <= 1'b0;
            eof   <= 1'b0;
         end else begin
            hsync <= (h >= H_S0) && (h <= H_S1);
            vsync <= (v >= V_S0) && (v <= V_S1);
            blank <= !act;
            col   <= act ? 11'(h) : '0;
            row   <= act ? 10'(v) : '0;
            sof   <= (h == '0) && (v == '0);
            eof   <= (h == H_AL) && (v == V_AL);
            if (last) frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a reduced raster.
// sof times are scoreboarded; other features checked inline.
module tb_video_timing_gen;

   localparam int HA = 8;
   localparam int HF = 2;
   localparam int HS = 3;
   localparam int HB = 3;
   localparam int VA = 4;
   localparam int VF = 1;
   localparam int VS = 2;
   localparam int VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FR = HT * VT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        hsync;
   logic        vsync;
   logic        blank;
   logic [10:0] col;
   logic [9:0]  row;
   logic        sof;
   logic        eof;
   logic [7:0]  frame_cnt;
   logic        busy;

   int cyc      = 0;
   int errors   = 0;
   int checks   = 0;
   int last_sof = -1;
   int sof_q[$];

   video_timing_gen #(
      .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .hsync     (hsync),
      .vsync     (vsync),
      .blank     (blank),
      .col       (col),
      .row       (row),
      .sof       (sof),
      .eof       (eof),
      .frame_cnt (frame_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // sof scoreboard: each pulse must match the next expected cycle.
   always @(negedge clk) begin
      if (sof === 1'b1) begin
         last_sof = cyc;
         checks++;
         if (sof_q.size() == 0) begin
            errors++;
            $display("FAIL sof_unexpected at cycle %0d", cyc);
         end else begin
            int e;
            e = sof_q.pop_front();
            if (cyc !== e) begin
               errors++;
               $display("FAIL sof_time got %0d want %0d", cyc, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      run = 1'b1;
      repeat (3) tick();
      checks++;
      if (blank !== 1'b1) begin
         errors++; $display("FAIL rst_blank got %b want 1", blank);
      end
      checks++;
      if (hsync !== 1'b0) begin
         errors++; $display("FAIL rst_hsync got %b want 0", hsync);
      end
      checks++;
      if (vsync !== 1'b0) begin
         errors++; $display("FAIL rst_vsync got %b want 0", vsync);
      end
      checks++;
      if (col !== 11'd0 || row !== 10'd0) begin
         errors++;
         $display("FAIL rst_colrow got %0d/%0d want 0/0", col, row);
      end
      checks++;
      if ({sof, eof} !== 2'b00) begin
         errors++; $display("FAIL rst_sofeof got %b want 00", {sof, eof});
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL rst_busy got %b want 0", busy);
      end
      checks++;
      if (frame_cnt !== 8'd0) begin
         errors++; $display("FAIL rst_fcnt got %0d want 0", frame_cnt);
      end
   endtask

   task automatic test_start();
      int c;
      run = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL idle_busy got %b want 0", busy);
      end
      run = 1'b1;
      c = cyc;
      sof_q.push_back(c + 2);
      sof_q.push_back(c + 2 + FR);
      sof_q.push_back(c + 2 + 2 * FR);
      while (cyc < c + 2 + 2 * FR + 1) tick();
      checks++;
      if (last_sof !== c + 2 + 2 * FR) begin
         errors++;
         $display("FAIL start_sof got %0d want %0d", last_sof,
                  c + 2 + 2 * FR);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL run_busy got %b want 1", busy);
      end
   endtask

   task automatic test_line();
      int s;
      int n;
      s = last_sof;
      sof_q.push_back(s + FR);
      sof_q.push_back(s + 2 * FR);
      n = 0;
      while (!(blank === 1'b0 && col == 11'd0 && row == 10'd1)
             && n < 2 * FR) begin
         tick(); n++;
      end
      checks++;
      if (n >= 2 * FR) begin
         errors++; $display("FAIL line_find got timeout want row1");
      end
      n = 1;
      while (n < 4 * HT) begin
         tick();
         if (blank) break;
         n++;
      end
      checks++;
      if (n !== HA) begin
         errors++; $display("FAIL line_active got %0d want %0d", n, HA);
      end
      n = 0;
      while (!hsync && n < 4 * HT) begin tick(); n++; end
      checks++;
      if (n !== HF) begin
         errors++; $display("FAIL line_fp got %0d want %0d", n, HF);
      end
      n = 0;
      while (hsync && n < 4 * HT) begin tick(); n++; end
      checks++;
      if (n !== HS) begin
         errors++; $display("FAIL line_hsync got %0d want %0d", n, HS);
      end
      n = 0;
      while (blank && n < 4 * HT) begin tick(); n++; end
      checks++;
      if (n !== HB) begin
         errors++; $display("FAIL line_bp got %0d want %0d", n, HB);
      end
      while (cyc < s + 2 * FR + 1) tick();
   endtask

   task automatic test_frame();
      int s;
      int n;
      int e;
      s = last_sof;
      sof_q.push_back(s + FR);
      sof_q.push_back(s + 2 * FR);
      n = 0;
      while (eof !== 1'b1 && n < 2 * FR) begin tick(); n++; end
      checks++;
      if (col !== 11'(HA - 1) || row !== 10'(VA - 1)) begin
         errors++;
         $display("FAIL eof_pos got %0d/%0d want %0d/%0d",
                  col, row, HA - 1, VA - 1);
      end
      e = cyc;
      n = 0;
      while (vsync !== 1'b1 && n < 2 * FR) begin tick(); n++; end
      checks++;
      if (cyc - e !== (HT - HA + 1) + VF * HT) begin
         errors++;
         $display("FAIL vsync_start got %0d want %0d", cyc - e,
                  (HT - HA + 1) + VF * HT);
      end
      n = 0;
      while (vsync === 1'b1 && n < 4 * FR) begin n++; tick(); end
      checks++;
      if (n !== VS * HT) begin
         errors++; $display("FAIL vsync_len got %0d want %0d", n, VS * HT);
      end
      while (cyc < s + 2 * FR + 1) tick();
   endtask

   task automatic test_drain();
      int s;
      int n;
      logic [7:0] fc;
      s = last_sof;
      n = 0;
      while (!(blank === 1'b0 && col == 11'd0 && row == 10'd2)
             && n < FR) begin
         tick(); n++;
      end
      fc = frame_cnt;
      run = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 2 * FR) begin tick(); n++; end
      checks++;
      if (cyc !== s + FR) begin
         errors++; $display("FAIL drain_end got %0d want %0d", cyc, s + FR);
      end
      checks++;
      if (frame_cnt !== fc + 8'd1) begin
         errors++;
         $display("FAIL drain_fcnt got %0d want %0d", frame_cnt, fc + 8'd1);
      end
      repeat (FR) tick();
      checks++;
      if ({blank, hsync, vsync, sof, eof, busy} !== 6'b100000
          || col !== 11'd0 || row !== 10'd0) begin
         errors++;
         $display("FAIL drain_idle got %b %0d %0d want 100000 0 0",
                  {blank, hsync, vsync, sof, eof, busy}, col, row);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      int n;
      logic drop;
      run = 1'b1;
      c = cyc;
      sof_q.push_back(c + 2);
      sof_q.push_back(c + 2 + FR);
      sof_q.push_back(c + 2 + 2 * FR);
      n = 0;
      while (!(blank === 1'b0 && col == 11'd0 && row == 10'd1)
             && n < 2 * FR) begin
         tick(); n++;
      end
      run = 1'b0;
      n = 0;
      while (!(blank === 1'b0 && col == 11'd0 && row == 10'd3)
             && n < 2 * FR) begin
         tick(); n++;
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL drain_busy got %b want 1", busy);
      end
      run = 1'b1;
      drop = 1'b0;
      while (cyc < c + 2 + 2 * FR + 1) begin
         tick();
         if (busy !== 1'b1) drop = 1'b1;
      end
      checks++;
      if (drop !== 1'b0) begin
         errors++; $display("FAIL rerun_busy got dropped want steady");
      end
      checks++;
      if (last_sof !== c + 2 + 2 * FR) begin
         errors++;
         $display("FAIL rerun_sof got %0d want %0d", last_sof,
                  c + 2 + 2 * FR);
      end
   endtask

   task automatic test_rst_mid();
      int n;
      int r;
      n = 0;
      while (!(blank === 1'b0 && col == 11'd5 && row == 10'd2)
             && n < 2 * FR) begin
         tick(); n++;
      end
      rst = 1'b1;
      tick();
      checks++;
      if (blank !== 1'b1 || col !== 11'd0) begin
         errors++;
         $display("FAIL rstmid_blank got %b/%0d want 1/0", blank, col);
      end
      checks++;
      if (frame_cnt !== 8'd0) begin
         errors++; $display("FAIL rstmid_fcnt got %0d want 0", frame_cnt);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL rstmid_busy got %b want 0", busy);
      end
      r = cyc;
      rst = 1'b0;
      sof_q.push_back(r + 2);
      while (cyc < r + 3) tick();
      checks++;
      if (last_sof !== r + 2) begin
         errors++; $display("FAIL rstrun_sof got %0d want %0d", last_sof, r + 2);
      end
   endtask

   task automatic test_wrap();
      int s;
      s = last_sof;
      checks++;
      if (frame_cnt !== 8'd0) begin
         errors++; $display("FAIL wrap_start got %0d want 0", frame_cnt);
      end
      for (int k = 1; k <= 256; k++) sof_q.push_back(s + k * FR);
      while (cyc < s + 256 * FR - 2) tick();
      checks++;
      if (frame_cnt !== 8'd255) begin
         errors++; $display("FAIL wrap_255 got %0d want 255", frame_cnt);
      end
      tick();
      checks++;
      if (frame_cnt !== 8'd0) begin
         errors++; $display("FAIL wrap_0 got %0d want 0", frame_cnt);
      end
      while (cyc < s + 256 * FR + 1) tick();
      rst = 1'b1;
      run = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (sof_q.size() !== 0) begin
         errors++;
         $display("FAIL sof_missing got %0d pending want 0", sof_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_line();
      test_frame();
      test_drain();
      test_back_to_back();
      test_rst_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACT, default 1280, meaning active pixels per line.
REQ-002 SHALL have parameter H_FP, default 110, meaning horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 40, meaning hsync width in clocks.
REQ-004 SHALL have parameter H_BP, default 220, meaning horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACT, default 720, meaning active lines per frame.
REQ-006 SHALL have parameters V_FP, V_SYNC and V_BP, defaults 5, 5 and 20, meaning vertical porches and sync width in lines.
REQ-007 SHALL have port clk, input, 1 bit: pixel clock, the single clock of the block.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port run, input, 1 bit: level request to generate frames.
REQ-010 SHALL have ports hsync, vsync and blank, outputs, 1 bit each: sync and blanking outputs, active-high.
REQ-011 SHALL have port col, output, 11 bits: active pixel column index.
REQ-012 SHALL have port row, output, 10 bits: active line index.
REQ-013 SHALL have ports sof and eof, outputs, 1 bit each: one-cycle pulses on the first and last active pixel of a frame.
REQ-014 SHALL have port frame_cnt, output, 8 bits: count of completed frames.
REQ-015 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE.

Function
REQ-016 SHALL define H_TOT = H_ACT+H_FP+H_SYNC+H_BP (1650) and V_TOT = V_ACT+V_FP+V_SYNC+V_BP (750).
REQ-017 SHALL use h counter 0..H_TOT-1 wrapping to 0, and increment v counter 0..V_TOT-1 only when h wraps.
REQ-018 SHALL lay out each line as active h<H_ACT, then front porch, sync H_ACT+H_FP <= h < H_ACT+H_FP+H_SYNC (1390..1429), then back porch 1430..1649.
REQ-019 SHALL assert vsync for full lines V_ACT+V_FP <= v < V_ACT+V_FP+V_SYNC (725..729), with edges aligned to h=0.
REQ-020 SHALL drive blank = NOT(h<H_ACT AND v<V_ACT).
REQ-021 SHALL drive col=h and row=v when not blanked, and 0 otherwise.
REQ-022 SHALL register all outputs, each describing the counter position of the previous cycle (one cycle latency).
REQ-023 SHALL use FSM states IDLE, RUN and DRAIN.
REQ-024 SHALL go IDLE->RUN when run=1 is sampled, with counters loaded to (0,0) on the first RUN cycle.
REQ-025 SHALL go RUN->DRAIN when run=0 is sampled.
REQ-026 SHALL go DRAIN->IDLE at the last position of the frame (h=H_TOT-1, v=V_TOT-1).
REQ-027 SHALL go DRAIN->RUN when run=1 is sampled again before that last position, with no disturbance to timing.
REQ-028 SHALL go RUN->RUN at the last frame position, wrapping to (0,0) with no gap cycle.
REQ-029 SHALL hold outputs in IDLE at blank=1, hsync=0, vsync=0, col=0, row=0, sof=0, eof=0, with counters at 0.
REQ-030 SHALL pulse sof at position (0,0) and eof at (H_ACT-1, V_ACT-1).
REQ-031 SHALL increment frame_cnt (mod 256, wrapping 255->0) at each frame's last position in RUN or DRAIN.
REQ-032 SHALL never truncate a frame because of a run toggle; only rst aborts mid-frame.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, force FSM=IDLE, h=v=0, frame_cnt=0 and all outputs to IDLE values on the next cycle, including mid-frame.
REQ-034 SHALL give rst priority over run; with run held high, the first RUN cycle is the first edge after rst deasserts.

Structure
REQ-035 SHALL place the timing default constants, H_TOT/V_TOT and the FSM state enum in shared package video_timing_pkg.
REQ-036 SHALL implement h and v with one sub-module, wrap_counter (parameterised modulus, enable, clear, terminal-count output), instantiated twice.

Verification
REQ-037 SHALL check: rst then run=1 held -> sof at output 2 cycles after the first run sample; 1,237,500 clocks between successive sof pulses.
REQ-038 SHALL check: one line measured -> blank low 1280 clocks, hsync high exactly 40 clocks starting 110 clocks after blank rises, 220 clocks from hsync fall to blank fall.
REQ-039 SHALL check: one frame measured -> vsync high 5×1650=8250 clocks, starting 5 lines after the last active line; eof at col=1279, row=719.
REQ-040 SHALL check: run dropped at line 300 -> frame completes, frame_cnt+1, busy falls at the frame end, outputs held at IDLE values.
REQ-041 SHALL check: run dropped then raised at line 400 -> no timing discontinuity, next sof exactly 1,237,500 clocks after the previous one.
REQ-042 SHALL check: rst pulse at h=500, v=200 -> next cycle blank=1, frame_cnt=0, busy=0; frame_cnt 255->0 wrap after 256 frames.
